// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arb
// Purpose  : Shares one 16-bit combinational ALU between two requesters with
//            round-robin arbitration. The granted requester's operands and
//            opcode drive the ALU in the grant cycle, and the ALU result and
//            flags are captured into a one-entry valid/ready output register
//            tagged with the requester id. Illegal opcodes are accepted but
//            trapped: the ALU sees a defined opcode and the response carries
//            a fixed result with an error bit.
// Ports    : clk, rst_n                  - clock, async active-low reset
//            req_valid/req_ready [1:0]   - per-requester handshake
//            req{0,1}_a/_b/_op           - requester operands and opcode
//            alu_a/alu_b/alu_sigs        - to the shared ALU (0 when idle)
//            alu_d, alu_vl/vh/z/n        - from the shared ALU
//            rsp_valid/rsp_ready         - response handshake
//            rsp_id/data/flags/err       - registered response
//            busy_cnt                    - saturating stall-cycle counter
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arb #(
    parameter int W   = 16,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_sigs,
    input  logic [W-1:0]   alu_d,
    input  logic           alu_vl,
    input  logic           alu_vh,
    input  logic           alu_z,
    input  logic           alu_n,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [W-1:0]   rsp_data,
    output logic [3:0]     rsp_flags,
    output logic           rsp_err,
    output logic [7:0]     busy_cnt
);

    localparam logic [OPW-1:0] c_op_xor    = OPW'(4'b0000);
    localparam logic [OPW-1:0] c_op_add    = OPW'(4'b0100);
    localparam logic [OPW-1:0] c_op_sub    = OPW'(4'b0101);
    localparam logic [OPW-1:0] c_op_paddsb = OPW'(4'b0110);
    localparam logic [OPW-1:0] c_op_nand   = OPW'(4'b1000);

    // Trapped result: zero data with only the Z flag set.
    localparam logic [3:0]     c_err_flags = 4'b0001;

    function automatic logic is_legal(input logic [OPW-1:0] op);
        return (op == c_op_xor) || (op == c_op_add) || (op == c_op_sub) ||
               (op == c_op_paddsb) || (op == c_op_nand);
    endfunction

    logic           r_rsp_valid;
    logic           r_rsp_id;
    logic [W-1:0]   r_rsp_data;
    logic [3:0]     r_rsp_flags;
    logic           r_rsp_err;
    logic [7:0]     r_busy_cnt;
    logic           r_ptr;          // requester that wins a tie

    logic           w_can_accept;
    logic           w_gnt;
    logic           w_gnt_id;
    logic           w_legal;
    logic [W-1:0]   w_a;
    logic [W-1:0]   w_b;
    logic [OPW-1:0] w_op;

    always_comb begin
        // A refill may coincide with the drain of the held result.
        w_can_accept = !r_rsp_valid || rsp_ready;
        w_gnt        = 1'b0;
        w_gnt_id     = 1'b0;
        // rst_n gates the grant so req_ready is low for the whole reset pulse,
        // including the part of the cycle before the next clock edge.
        if (rst_n && w_can_accept) begin
            if (req_valid == 2'b11) begin
                w_gnt    = 1'b1;
                w_gnt_id = r_ptr;
            end else if (req_valid[0]) begin
                w_gnt    = 1'b1;
            end else if (req_valid[1]) begin
                w_gnt    = 1'b1;
                w_gnt_id = 1'b1;
            end
        end
        w_a     = w_gnt_id ? req1_a  : req0_a;
        w_b     = w_gnt_id ? req1_b  : req0_b;
        w_op    = w_gnt_id ? req1_op : req0_op;
        w_legal = is_legal(w_op);
    end

    assign req_ready = {w_gnt & w_gnt_id, w_gnt & ~w_gnt_id};
    assign alu_a     = w_gnt ? w_a : '0;
    assign alu_b     = w_gnt ? w_b : '0;
    // Illegal codes are replaced by xor so the ALU input is always defined.
    assign alu_sigs  = (w_gnt && w_legal) ? w_op : c_op_xor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_flags <= 4'b0000;
            r_rsp_err   <= 1'b0;
            r_busy_cnt  <= 8'h00;
            r_ptr       <= 1'b0;
        end else begin
            if (w_gnt) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= w_gnt_id;
                r_ptr       <= ~w_gnt_id;
                if (w_legal) begin
                    r_rsp_data  <= alu_d;
                    r_rsp_flags <= {alu_vh, alu_vl, alu_n, alu_z};
                    r_rsp_err   <= 1'b0;
                end else begin
                    r_rsp_data  <= '0;
                    r_rsp_flags <= c_err_flags;
                    r_rsp_err   <= 1'b1;
                end
            end else if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end

            if ((|req_valid) && !w_gnt && (r_busy_cnt != 8'hFF)) begin
                r_busy_cnt <= r_busy_cnt + 8'd1;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_flags = r_rsp_flags;
    assign rsp_err   = r_rsp_err;
    assign busy_cnt  = r_busy_cnt;

endmodule
`default_nettype wire
